// File: rtl/imm_enc_if.sv
// Immediate encoder types and valid/ready bus.
// Shared by the encoder and its producers/consumers.
package imm_pkg;
  typedef enum logic [2:0] {
    SE20_UI = 3'd0,
    SE12_LI = 3'd1,
    SE05    = 3'd2,
    SE12_BR = 3'd3,
    SE12_ST = 3'd4,
    SE20_JP = 3'd5
  } imm_ctrl;
endpackage

interface imm_enc_if;
   import imm_pkg::*;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_imm;
   imm_ctrl     in_sel;
   logic [24:0] in_base;
   logic        out_valid;
   logic        out_ready;
   logic [24:0] out_field;
   logic        out_err;

   modport slave (
      input  in_valid, in_imm, in_sel, in_base, out_ready,
      output in_ready, out_valid, out_field, out_err
   );

   modport master (
      output in_valid, in_imm, in_sel, in_base, out_ready,
      input  in_ready, out_valid, out_field, out_err
   );
endinterface

// File: rtl/imm_enc.sv
// Immediate encoder: range-checks an immediate and scatters it into
// inst[31:7] over a base word; 2-stage valid/ready pipe + error counter.
module imm_enc
   import imm_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   imm_enc_if.slave         bus,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   logic [31:0] imm;
   logic [24:0] mask;
   logic [24:0] packed_f;
   logic        err;
   logic        sx12;
   logic        sx13;
   logic        sx21;

   logic        s1_valid;
   logic [24:0] s1_base;
   logic [24:0] s1_mask;
   logic [24:0] s1_packed;
   logic        s1_err;

   logic        s2_adv;
   logic        out_hs;

   assign imm  = bus.in_imm;
   assign sx12 = (&imm[31:11]) | ~(|imm[31:11]);
   assign sx13 = (&imm[31:12]) | ~(|imm[31:12]);
   assign sx21 = (&imm[31:20]) | ~(|imm[31:20]);

   always_comb begin
      mask     = '0;
      packed_f = '0;
      err      = 1'b0;
      case (bus.in_sel)
         SE20_UI: begin
            mask     = 25'h1FFFFE0;
            packed_f = {imm[31:12], 5'b0};
            err      = |imm[11:0];
         end
         SE12_LI: begin
            mask     = 25'h1FFE000;
            packed_f = {imm[11:0], 13'b0};
            err      = !sx12;
         end
         SE05: begin
            mask     = 25'h003E000;
            packed_f = {7'b0, imm[4:0], 13'b0};
            err      = |imm[31:5];
         end
         SE12_ST: begin
            mask     = 25'h1FC001F;
            packed_f = {imm[11:5], 13'b0, imm[4:0]};
            err      = !sx12;
         end
         SE12_BR: begin
            mask     = 25'h1FC001F;
            packed_f = {imm[12], imm[10:5], 13'b0,
                        imm[4:1], imm[11]};
            err      = !sx13 || imm[0];
         end
         SE20_JP: begin
            mask     = 25'h1FFFFE0;
            packed_f = {imm[20], imm[10:1], imm[11],
                        imm[19:12], 5'b0};
            err      = !sx21 || imm[0];
         end
         default: begin
            mask     = '0;
            packed_f = '0;
            err      = 1'b0;
         end
      endcase
   end

   assign s2_adv       = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = !s1_valid || s2_adv;
   assign out_hs       = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid  <= 1'b0;
         s1_base   <= '0;
         s1_mask   <= '0;
         s1_packed <= '0;
         s1_err    <= 1'b0;
      end else if (bus.in_ready) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_base   <= bus.in_base;
            s1_mask   <= mask;
            s1_packed <= packed_f;
            s1_err    <= err;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bus.out_valid <= 1'b0;
         bus.out_field <= '0;
         bus.out_err   <= 1'b0;
      end else if (s2_adv) begin
         bus.out_valid <= s1_valid;
         if (s1_valid) begin
            bus.out_field <= (s1_base & ~s1_mask) | s1_packed;
            bus.out_err   <= s1_err;
         end
      end
   end

   // clear wins, but an erroring handshake in the same cycle still counts
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_cnt <= '0;
      end else if (clr_cnt) begin
         err_cnt <= (out_hs && bus.out_err) ? CNT_W'(1) : '0;
      end else if (out_hs && bus.out_err && !(&err_cnt)) begin
         err_cnt <= err_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_imm_enc.sv
// Scoreboard bench for imm_enc: randomized and directed transactions
// checked against a bit-map/range reference model.
module tb_imm_enc;
  import imm_pkg::*;

  typedef struct packed {
    logic [24:0] f;
    logic        e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       clr_cnt = 1'b0;
  logic [7:0] err_cnt;
  bit         rand_rdy = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         exp_cnt = 0;
  exp_t       q[$];

  imm_enc_if bus();

  imm_enc #(.CNT_W(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus),
    .clr_cnt(clr_cnt),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] imm,
                                 input logic [2:0] sel,
                                 input logic [24:0] base);
    exp_t r;
    int   si;
    si  = $signed(imm);
    r.f = base;
    r.e = 1'b0;
    case (sel)
      3'd0: begin
        for (int k = 5; k < 25; k++) r.f[k] = imm[k+7];
        r.e = (imm % 4096) != 0;
      end
      3'd1: begin
        for (int k = 13; k < 25; k++) r.f[k] = imm[k-13];
        r.e = si < -2048 || si > 2047;
      end
      3'd2: begin
        for (int k = 13; k < 18; k++) r.f[k] = imm[k-13];
        r.e = imm > 32'd31;
      end
      3'd3: begin
        r.f[24] = imm[12];
        for (int k = 18; k < 24; k++) r.f[k] = imm[k-13];
        for (int k = 1; k < 5; k++) r.f[k] = imm[k];
        r.f[0] = imm[11];
        r.e = si < -4096 || si > 4095 || imm[0];
      end
      3'd4: begin
        for (int k = 18; k < 25; k++) r.f[k] = imm[k-13];
        for (int k = 0; k < 5; k++) r.f[k] = imm[k];
        r.e = si < -2048 || si > 2047;
      end
      3'd5: begin
        r.f[24] = imm[20];
        for (int k = 14; k < 24; k++) r.f[k] = imm[k-13];
        r.f[13] = imm[11];
        for (int k = 5; k < 13; k++) r.f[k] = imm[k+7];
        r.e = si < -(1 << 20) || si > (1 << 20) - 1 || imm[0];
      end
      default: r.e = 1'b0;
    endcase
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(3) != 0);
  endtask

  task automatic send(input logic [31:0] imm, input logic [2:0] sel,
                      input logic [24:0] base, input bit use_exp,
                      input logic [24:0] ef, input logic ee);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    e  = model(imm, sel, base);
    if (use_exp) begin
      e.f = ef;
      e.e = ee;
    end
    bus.in_valid = 1'b1;
    bus.in_imm   = imm;
    bus.in_sel   = imm_ctrl'(sel);
    bus.in_base  = base;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        q.push_back(e);
      end
      tick();
    end
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: in_ready stuck 0");
    end
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 300 && q.size() != 0; c++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  function automatic logic [31:0] rnd_imm();
    logic [31:0] v;
    case ($urandom_range(4))
      0: v = $urandom;
      1: v = $urandom_range(8191) - 4096;
      2: v = $urandom_range(32'h3FFFFF) - 32'h200000;
      3: v = $urandom & 32'hFFFFF000;
      default: v = $urandom_range(63);
    endcase
    if ($urandom_range(1) == 1) v[0] = 1'b0;
    return v;
  endfunction

  initial begin : monitor
    exp_t e;
    logic hs_err;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        exp_cnt = 0;
        q.delete();
      end else begin
        chk("err_cnt", 32'(err_cnt), exp_cnt);
        hs_err = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: field %h", bus.out_field);
          end else begin
            e = q.pop_front();
            chk("out_field", 32'(bus.out_field), 32'(e.f));
            chk("out_err", 32'(bus.out_err), 32'(e.e));
            hs_err = e.e;
          end
        end
        if (clr_cnt) exp_cnt = hs_err ? 1 : 0;
        else if (hs_err && exp_cnt != 255) exp_cnt++;
      end
    end
  end

  initial begin : stim
    logic [24:0] held_f;
    logic        held_e;
    bus.in_valid  = 1'b0;
    bus.in_imm    = '0;
    bus.in_sel    = SE20_UI;
    bus.in_base   = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_field", 32'(bus.out_field), 0);
    chk("rst_out_err", 32'(bus.out_err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    tick();
    rst_ni = 1'b1;
    tick();

    send(32'hFFFFFFFF, 3'd1, 25'h0, 1, 25'h1FFE000, 1'b0);
    bus.in_valid = 1'b0;
    chk("lat_n", 32'(bus.out_valid), 0);
    tick();
    chk("lat_n1", 32'(bus.out_valid), 1);
    send(32'hFFFFFFFE, 3'd3, 25'h0, 1, 25'h1FC001F, 1'b0);
    send(32'h3, 3'd3, 25'h0, 0, 25'h0, 1'b0);
    send(32'h1000, 3'd3, 25'h0, 0, 25'h0, 1'b0);
    send(32'hFFFFF000, 3'd3, 25'h0, 0, 25'h0, 1'b0);
    send(32'h12345000, 3'd0, 25'h0, 1, 25'h02468A0, 1'b0);
    send(32'h12345001, 3'd0, 25'h0, 0, 25'h0, 1'b0);
    send(32'h800, 3'd5, 25'h0, 1, 25'h0002000, 1'b0);
    send(32'h00100000, 3'd5, 25'h0, 0, 25'h0, 1'b0);
    send(32'h0, 3'd4, 25'h1FFFFFF, 1, 25'h003FFE0, 1'b0);
    send(32'hDEADBEEF, 3'd7, 25'h0ABCDEF, 1, 25'h0ABCDEF, 1'b0);
    send(32'h1F, 3'd2, 25'h0, 0, 25'h0, 1'b0);
    send(32'h20, 3'd2, 25'h0, 0, 25'h0, 1'b0);
    drain();

    bus.out_ready = 1'b0;
    send(32'h7FF, 3'd1, 25'h1234567, 0, 25'h0, 1'b0);
    send(32'hFFFFF800, 3'd4, 25'h0F0F0F0, 0, 25'h0, 1'b0);
    chk("bp_in_ready", 32'(bus.in_ready), 0);
    held_f = bus.out_field;
    held_e = bus.out_err;
    chk("bp_valid", 32'(bus.out_valid), 1);
    fork
      begin
        send(32'h5, 3'd2, 25'h1555555, 0, 25'h0, 1'b0);
        send(32'h12345, 3'd0, 25'h0, 0, 25'h0, 1'b0);
        send(32'hFFE, 3'd5, 25'h1FFFFFF, 0, 25'h0, 1'b0);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_f", 32'(bus.out_field), 32'(held_f));
          chk("bp_hold_e", 32'(bus.out_err), 32'(held_e));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(rnd_imm(), 3'($urandom_range(7)), 25'($urandom), 0,
           25'h0, 1'b0);
      if ($urandom_range(3) == 0) begin
        bus.in_valid = 1'b0;
        tick();
      end
    end
    drain();
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    tick();

    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    for (int i = 0; i < 300; i++)
      send(32'h20 + $urandom_range(1000), 3'd2, 25'($urandom), 0,
           25'h0, 1'b0);
    drain();
    tick();
    chk("cnt_sat", 32'(err_cnt), 255);

    send(32'h3, 3'd3, 25'h0, 0, 25'h0, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("cnt_clr_hs", 32'(err_cnt), 1);

    send(32'hFFF, 3'd1, 25'h0, 0, 25'h0, 1'b0);
    send(32'h1, 3'd5, 25'h0, 0, 25'h0, 1'b0);
    bus.in_valid = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_cnt", 32'(err_cnt), 0);
    chk("mid_rst_ready", 32'(bus.in_ready), 1);
    q.delete();
    tick();
    rst_ni = 1'b1;
    tick();
    send(32'h123, 3'd4, 25'h0, 0, 25'h0, 1'b0);
    drain();
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imm_enc.md
# imm_enc

Immediate encoder for the instruction-assembly path: it is the inverse of the core's immediate generator. It takes a 32-bit immediate, an `imm_ctrl` format select and a base field word. It range-checks the immediate and scatters its bits into `inst[31:7]`, merging them over the base (rd/funct3/rs1/rs2) bits. It sits between the test-program generator / patch unit and instruction memory writes, as a 2-stage valid/ready pipeline with a saturating error counter.

## Interface
- `CNT_W`, default 8: width of the error counter.
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  input transaction valid.
- `in_ready`  out  1  input accepted when `in_valid && in_ready`.
- `in_imm`  in  32  immediate value, two's complement.
- `in_sel`  in  `imm_ctrl`  format: `SE20_UI`, `SE12_LI`, `SE05`, `SE12_BR`, `SE12_ST`, `SE20_JP`.
- `in_base`  in  25  base `inst[31:7]`; bits outside the immediate mask pass through.
- `out_valid`  out  1  output valid.
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`.
- `out_field`  out  25  encoded `inst[31:7]`.
- `out_err`  out  1  immediate not representable in the selected format.
- `clr_cnt`  in  1  synchronous clear of `err_cnt`.
- `err_cnt`  out  CNT_W  saturating count of transactions delivered with `out_err=1`.

## Operation
- Notation: `f[k]` = `inst[k+7]`. Pack map, with the mask being the bits written:
  - U (`SE20_UI`): `f[24:5]=imm[31:12]`.
  - I (`SE12_LI`): `f[24:13]=imm[11:0]`.
  - SHAMT (`SE05`): `f[17:13]=imm[4:0]`.
  - S (`SE12_ST`): `f[24:18]=imm[11:5]`, `f[4:0]=imm[4:0]`.
  - B (`SE12_BR`): `f[24]=imm[12]`, `f[23:18]=imm[10:5]`, `f[4:1]=imm[4:1]`, `f[0]=imm[11]`.
  - J (`SE20_JP`): `f[24]=imm[20]`, `f[23:14]=imm[10:1]`, `f[13]=imm[11]`, `f[12:5]=imm[19:12]`.
- Merge: `out_field = (in_base & ~mask) | packed`.
- Any other `in_sel` value: mask = 0, so `out_field = in_base` and `out_err = 0`.
- Error rules, evaluated on the full 32-bit `in_imm`:
  - U: error iff `imm[11:0] != 0`.
  - I and S: error iff `imm` is not sign-extension of `imm[11:0]`.
  - SHAMT: error iff `imm[31:5] != 0`.
  - B: error iff `imm` is not sign-extension of `imm[12:0]`, or `imm[0]=1`.
  - J: error iff `imm` is not sign-extension of `imm[20:0]`, or `imm[0]=1`.
- On error the packed bits are still the truncated bits per the map; only `out_err` differs.
- Stage 1 registers the inputs, the computed `mask`/`packed`, and the error flag. Stage 2 registers the merged `out_field` and `out_err`.
- `err_cnt` increments on each output handshake with `out_err=1` and saturates at `2^CNT_W-1`.
- `clr_cnt` has priority. If `clr_cnt` coincides with an erroring handshake, `err_cnt` becomes 1.

## Timing
- Reset (`rst_ni` low, takes effect immediately): both stage valids = 0, `out_valid=0`, `out_field=0`, `out_err=0`, `err_cnt=0`.
- `in_ready` is combinational from state: `in_ready = !s1_valid || (!s2_valid || out_ready)`. It reads 1 while in reset; inputs are ignored while `rst_ni` is low.
- Latency: a transaction accepted at edge N has `out_valid=1` after edge N+1, i.e. 2 registered stages.
- Throughput: 1 transaction per cycle when `out_ready=1`.
- Backpressure:
  - While `out_valid && !out_ready`, `out_field` and `out_err` hold stable.
  - Stage 1 holds if stage 2 is stalled.
  - At most 2 transactions are in flight. None are lost or reordered.
- Simultaneous events:
  - Stage 2 may consume and refill in the same cycle.
  - Stage 1 may accept while advancing.
- Reset mid-operation discards all in-flight transactions. `err_cnt` returns to 0.

## Test plan
- I: `in_imm=0xFFFFFFFF`, `in_base=0` -> `out_field=0x1FFE000`, `out_err=0`, 2 cycles after accept.
- B: `in_imm=0xFFFFFFFE`, `base=0` -> `0x1FC001F`, err 0. `imm=3` -> err 1. `imm=0x1000` -> err 1. `imm=0xFFFFF000` -> err 0.
- U/J:
  - U `imm=0x12345000` -> `0x02468A0`, err 0. U `imm=0x12345001` -> err 1.
  - J `imm=0x800` -> `0x0002000`. J `imm=0x00100000` -> err 1.
- Merge: S, `imm=0`, `base=0x1FFFFFF` -> `0x003FFE0`. `in_sel` outside the six formats, `base=0x0ABCDEF` -> `0x0ABCDEF`, err 0.
- Backpressure: drive 5 back-to-back transactions with `out_ready=0` -> `in_ready` drops after 2 are accepted. With `out_ready` then held high, all 5 emerge in order, values unchanged while stalled.
- Counter: 300 erroring handshakes -> `err_cnt=255`. `clr_cnt` with a concurrent erroring handshake -> 1. Assert `rst_ni=0` mid-stream -> `out_valid=0` and `err_cnt=0` immediately.
